// File: rtl/multi_clock_divider_if.sv
// Control and output bundle for multi_clock_divider.
// The master drives enable, sync and divisor writes; the slave returns the divided clocks and ticks.
interface multi_clock_divider_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 27,
  parameter int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              en;
  logic              sync;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, sync, div_we, div_sel, div_val,
    input  clk_out, tick
  );

  modport slave (
    input  en, sync, div_we, div_sel, div_val,
    output clk_out, tick
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Bank of NUM_CH programmable 50 % duty clock dividers with per-channel tick strobes.
// Define DIV_GLITCHFREE_EN to defer divisor writes to the channel's terminal count.
module multi_clock_divider #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned DEF_HALF = 62500000
) (
  input logic                  Clock_in,
  input logic                  Reset,
  multi_clock_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] DefHalf = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);
  localparam logic [CNT_W-1:0] Zero    = '0;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [CNT_W-1:0]  half  [NUM_CH];
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [31:0]       sel_ext;

  always_comb begin
    sel_ext = 32'(bus.div_sel);
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range selects never match any channel index, so they are dropped here.
      wr[i]     = bus.div_we && (sel_ext == 32'(i));
      half[i]   = (act_q[i] == Zero) ? One : act_q[i];
      term[i]   = (cnt_q[i] == half[i] - One);
      shd_d[i]  = wr[i] ? bus.div_val : shd_q[i];
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;

      if (bus.sync) begin
        cnt_d[i] = Zero;
        clk_d[i] = 1'b0;
        act_d[i] = wr[i] ? bus.div_val : shd_q[i];
      end
`ifdef DIV_GLITCHFREE_EN
      else if (bus.en) begin
        if (term[i]) begin
          cnt_d[i]  = Zero;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          act_d[i]  = wr[i] ? bus.div_val : shd_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + One;
        end
      end
`else
      // Immediate reload restarts the phase without touching the output level.
      else if (wr[i]) begin
        cnt_d[i] = Zero;
        act_d[i] = bus.div_val;
      end else if (bus.en) begin
        if (term[i]) begin
          cnt_d[i]  = Zero;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + One;
        end
      end
`endif
    end
  end

  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= Zero;
        act_q[i] <= DefHalf;
        shd_q[i] <= DefHalf;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench: a 2-channel and a 3-channel divider share one stimulus stream and are
// compared every cycle against a remaining-cycles reference model.
module tb_multi_clock_divider;
  localparam int unsigned CntW    = 8;
  localparam int unsigned DefHalf = 4;

  logic Clock_in = 1'b0;
  logic Reset    = 1'b1;
  always #5 Clock_in = ~Clock_in;

  multi_clock_divider_if #(.NUM_CH(2), .CNT_W(CntW)) bus2 ();
  multi_clock_divider_if #(.NUM_CH(3), .CNT_W(CntW)) bus3 ();

  multi_clock_divider #(.NUM_CH(2), .CNT_W(CntW), .DEF_HALF(DefHalf)) dut2 (
    .Clock_in(Clock_in), .Reset(Reset), .bus(bus2)
  );
  multi_clock_divider #(.NUM_CH(3), .CNT_W(CntW), .DEF_HALF(DefHalf)) dut3 (
    .Clock_in(Clock_in), .Reset(Reset), .bus(bus3)
  );

  // Reference state: cycles left until the next toggle, rather than an up-counter.
  int rem [3];
  int act [3];
  int shd [3];
  bit lvl [3];
  bit tk  [3];
  int checks = 0;
  int passed = 0;

  function automatic int hp(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit sync, input bit we,
                            input int sel, input int val);
    for (int i = 0; i < 3; i++) begin
      bit w;
      w = we && (sel == i);
      if (rst) begin
        act[i] = DefHalf; shd[i] = DefHalf; rem[i] = hp(DefHalf); lvl[i] = 0; tk[i] = 0;
      end else begin
        tk[i] = 0;
        if (sync) begin
          lvl[i] = 0;
          act[i] = w ? val : shd[i];
          rem[i] = hp(act[i]);
        end
`ifdef DIV_GLITCHFREE_EN
        else if (en) begin
          if (rem[i] == 1) begin
            lvl[i] = ~lvl[i]; tk[i] = 1;
            act[i] = w ? val : shd[i];
            rem[i] = hp(act[i]);
          end else rem[i]--;
        end
`else
        else if (w) begin
          act[i] = val;
          rem[i] = hp(val);
        end else if (en) begin
          if (rem[i] == 1) begin
            lvl[i] = ~lvl[i]; tk[i] = 1; rem[i] = hp(act[i]);
          end else rem[i]--;
        end
`endif
        if (w) shd[i] = val;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [2:0] ec, et;
    for (int i = 0; i < 3; i++) begin
      ec[i] = lvl[i];
      et[i] = tk[i];
    end
    checks++;
    assert (bus3.clk_out === ec) passed++;
    else $error("FAIL %s clk_out3 got %b exp %b", tag, bus3.clk_out, ec);
    checks++;
    assert (bus3.tick === et) passed++;
    else $error("FAIL %s tick3 got %b exp %b", tag, bus3.tick, et);
    checks++;
    assert (bus2.clk_out === ec[1:0]) passed++;
    else $error("FAIL %s clk_out2 got %b exp %b", tag, bus2.clk_out, ec[1:0]);
    checks++;
    assert (bus2.tick === et[1:0]) passed++;
    else $error("FAIL %s tick2 got %b exp %b", tag, bus2.tick, et[1:0]);
  endtask

  task automatic step(input bit rst, input bit en, input bit sync, input bit we,
                      input int sel, input int val, input string tag);
    logic [1:0] s;
    s            = 2'(sel);
    Reset        = rst;
    bus3.en      = en;
    bus3.sync    = sync;
    bus3.div_we  = we;
    bus3.div_sel = s;
    bus3.div_val = CntW'(val);
    bus2.en      = en;
    bus2.sync    = sync;
    bus2.div_we  = we && (sel < 2);
    bus2.div_sel = s[0];
    bus2.div_val = CntW'(val);
    @(posedge Clock_in);
    model_step(rst, en, sync, we, sel, val);
    #1;
    check(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model_step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, "reset");
    repeat (12) step(0, 1, 0, 0, 0, 0, "run");
    step(0, 1, 0, 1, 1, 2, "wr_ch1");
    repeat (10) step(0, 1, 0, 0, 0, 0, "after_wr");
    repeat (2) step(0, 1, 0, 0, 0, 0, "pre_hold");
    repeat (5) step(0, 0, 0, 0, 0, 0, "hold");
    repeat (6) step(0, 1, 0, 0, 0, 0, "resume");
    step(0, 1, 0, 1, 0, 0, "wr_ch0_zero");
    step(0, 0, 1, 0, 0, 0, "sync");
    repeat (6) step(0, 1, 0, 0, 0, 0, "h1");
    step(0, 1, 0, 1, 3, 7, "sel_oob");
    repeat (6) step(0, 1, 0, 0, 0, 0, "after_oob");
    step(0, 1, 0, 1, 0, 6, "wr_at_term");
    repeat (14) step(0, 1, 0, 0, 0, 0, "h6");
    step(0, 1, 0, 1, 2, 3, "wr_ch2");
    repeat (3) step(0, 1, 0, 0, 0, 0, "pre_rst");
    step(1, 1, 0, 0, 0, 0, "mid_reset");
    repeat (10) step(0, 1, 0, 0, 0, 0, "post_reset");
    step(0, 1, 1, 1, 1, 5, "sync_wr");
    repeat (12) step(0, 1, 0, 0, 0, 0, "post_sync_wr");
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), "random");
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
